fixed_sqrt_seq: RTL and testbench
=================================

Name: fixed_sqrt_seq

Overview:
Sequential fixed-point square-root responder on the far side of the startSqrt/readySqrt handshake that the normal datapath drives; the normal path uses it to normalise the cross-product length.
- Accepts one signed Q(WIDTH-FRAC).FRAC radicand per request.
- Computes the root with a digit-by-digit restoring algorithm, one root bit per cycle.
- Holds the result until the initiator issues the next request.

Parameters:
WIDTH, 32, total bits of the fixed type (matches math_pack fixed)
FRAC, 16, fractional bits of the fixed type
ITER (localparam), (WIDTH+FRAC)/2, iterations = root bits produced; 24 at defaults

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request strobe from initiator (startSqrt)
radicand  in  WIDTH  signed fixed operand, sampled when the request is accepted
ready  out  1  result valid (readySqrt); level signal
busy  out  1  iteration in progress
root  out  WIDTH  fixed result, same Q format as radicand
err  out  1  radicand was negative

Behaviour:
- Reset (reset=0, async): state IDLE; ready=0, busy=0, root=0, err=0, internal regs cleared. Reset mid-CALC aborts the operation with no result.
- States: IDLE, CALC, DONE.
- IDLE: start=1 at a clock edge accepts the request.
  - radicand<0: go directly to DONE with root=0 and err=1. ready rises the next edge.
  - Otherwise: latch R = {radicand, FRAC zeros} (WIDTH+FRAC bits, unsigned), clear partial root q and remainder, set busy=1, err=0, go to CALC with cnt=ITER-1.
- CALC, each cycle:
  - rem' = (rem<<2) | next two MSBs of R.
  - trial = (q<<2)|1.
  - If rem' >= trial: rem=rem'-trial and q=(q<<1)|1.
  - Else: rem=rem' and q=q<<1.
  - When cnt==0, go to DONE; otherwise decrement cnt.
- DONE:
  - ready=1, busy=0.
  - root = zero-extended q (ITER ≤ WIDTH, so no overflow).
  - Remains in DONE with ready held high and root/err stable until start=1. That start is accepted as a new request: ready drops on the same edge and the FSM proceeds exactly as from IDLE.
- Latency: start accepted at edge N, so ready=1 after edge N+ITER+1 (25 cycles at defaults). Negative-input path: ready=1 after edge N+1.
- start while in CALC is ignored; there is no queueing.
- Zero radicand follows the normal path and gives root=0, err=0 with full latency.
- root = floor(sqrt(radicand·2^FRAC)), i.e. truncation, unless the optional feature below is enabled.
- Arithmetic widths: remainder is ITER+2 bits and q is ITER bits; all comparisons are unsigned.

Optional Feature:
Macro SQRT_ROUND_EN.
- Defined: on the DONE transition, if final rem > q, root = q+1 (round-to-nearest; ties cannot occur for integer radicands). q+1 ≤ 2^ITER always fits in WIDTH. Latency is unchanged.
- Undefined: root = q (truncated); no extra comparator is present.

Decomposition:
- math_pack: fixed typedef, WIDTH/FRAC constants, and a sqrt_state_t enum {IDLE, CALC, DONE}.
- definitions_pack: unchanged.
- One natural sub-module: fixed_sqrt_step. It is purely combinational, takes (rem, q, two radicand bits) and returns (rem', q'). It is instantiated once; the FSM and registers stay in fixed_sqrt_seq.

Test Plan:
1. Radicand 0x00040000 (4.0) with start pulse → after 25 cycles ready=1, root=0x00020000, err=0; ready stays high until next start.
2. Radicand 0x00020000 (2.0) → root=0x00016A09 without SQRT_ROUND_EN; 0x00016A0A with it.
3. Radicand 0x7FFFFFFF (max) → root=0x00B504F3, err=0. Radicand 0x00000000 → root=0, 25-cycle latency.
4. Radicand 0xFFFF0000 (−1.0) → ready=1 two edges after start, root=0, err=1. A following start with 0x00010000 → err=0, root=0x00010000.
5. Assert start again at cycle 10 of a CALC for 9.0 (0x00090000) → ignored; result 0x00030000 at the original time. A start in DONE immediately begins the next operation, with ready dropping that edge.
6. Drop reset at cycle 12 of CALC → ready/busy/root/err=0 immediately. After release, a new start with 0x00190000 (25.0) → root=0x00050000.

Source files
------------

// File: rtl/math_pack.sv
// Shared fixed-point constants, the fixed type, and the square-root FSM state encoding.
package math_pack;

    localparam int unsigned FIXED_WIDTH = 32;
    localparam int unsigned FIXED_FRAC  = 16;

    typedef logic signed [FIXED_WIDTH-1:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sqrt_state_t;

endpackage

// File: rtl/fixed_sqrt_step.sv
// One restoring square-root iteration: shifts two radicand bits into the remainder
// and decides the next root bit by a trial subtraction.
module fixed_sqrt_step #(
    parameter int unsigned ITER = 24
) (
    input  logic [ITER+1:0] rem_i,
    input  logic [ITER-1:0] q_i,
    input  logic [1:0]      bits_i,
    output logic [ITER+1:0] rem_o,
    output logic [ITER-1:0] q_o
);

    localparam int unsigned REM_W = ITER + 2;

    logic [REM_W-1:0] rem_sh;
    logic [REM_W-1:0] trial;
    logic             fits;

    always_comb begin
        rem_sh = (rem_i << 2) | {{ITER{1'b0}}, bits_i};
        trial  = {q_i, 2'b01};
        fits   = (rem_sh >= trial);
        rem_o  = fits ? (rem_sh - trial) : rem_sh;
        q_o    = (q_i << 1) | ITER'(fits);
    end

endmodule

// File: rtl/fixed_sqrt_seq.sv
// Sequential fixed-point square root, one root bit per cycle behind a start/ready handshake.
// Optional SQRT_ROUND_EN rounds the root to nearest instead of truncating.
module fixed_sqrt_seq
    import math_pack::*;
#(
    parameter int unsigned WIDTH = FIXED_WIDTH,
    parameter int unsigned FRAC  = FIXED_FRAC
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] radicand,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] root,
    output logic             err
);

    localparam int unsigned ITER  = (WIDTH + FRAC) / 2;
    localparam int unsigned RW    = WIDTH + FRAC;
    localparam int unsigned REM_W = ITER + 2;
    localparam int unsigned CW    = (ITER > 1) ? $clog2(ITER) : 1;

    sqrt_state_t      state_q, state_d;
    logic [RW-1:0]    r_q, r_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [ITER-1:0]  q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] root_q, root_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic [REM_W-1:0] step_rem;
    logic [ITER-1:0]  step_q;
    logic [WIDTH-1:0] root_c;
    logic             accept;

    fixed_sqrt_step #(
        .ITER (ITER)
    ) u_step (
        .rem_i  (rem_q),
        .q_i    (q_q),
        .bits_i (r_q[RW-1 -: 2]),
        .rem_o  (step_rem),
        .q_o    (step_q)
    );

    // Final root from the settled partial root (and remainder when rounding)
`ifdef SQRT_ROUND_EN
    logic round_up;
    assign round_up = (rem_q > REM_W'(q_q));
    assign root_c   = WIDTH'(q_q) + WIDTH'(round_up);
`else
    assign root_c   = WIDTH'(q_q);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            root_q  <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            root_q  <= root_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        rem_d   = rem_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        root_d  = root_q;
        err_d   = err_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                accept = start;
            end
            CALC: begin
                busy_d = 1'b1;
                rem_d  = step_rem;
                q_d    = step_q;
                r_d    = r_q << 2;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                root_d  = root_c;
                accept  = start;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new request overrides whatever IDLE/DONE would have presented
        if (accept) begin
            ready_d = 1'b0;
            root_d  = '0;
            rem_d   = '0;
            q_d     = '0;
            if (radicand[WIDTH-1]) begin
                state_d = DONE;
                err_d   = 1'b1;
                busy_d  = 1'b0;
                r_d     = '0;
                cnt_d   = '0;
            end else begin
                state_d = CALC;
                err_d   = 1'b0;
                busy_d  = 1'b1;
                r_d     = {radicand, {FRAC{1'b0}}};
                cnt_d   = CW'(ITER - 1);
            end
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign root  = root_q;
    assign err   = err_q;

endmodule

// File: tb/tb_fixed_sqrt_seq.sv
// Self-checking bench for fixed_sqrt_seq: directed vector table, handshake corner
// sequences, and random operands against an integer square-root reference.
module tb_fixed_sqrt_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] radicand;
    logic        ready;
    logic        busy;
    logic [31:0] root;
    logic        err;

    int checks;
    int failures;

    fixed_sqrt_seq dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .radicand (radicand),
        .ready    (ready),
        .busy     (busy),
        .root     (root),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rad;
        logic [31:0] exp_root;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Largest r with r*r <= v, by bisection
    function automatic longint unsigned isqrt(input longint unsigned v);
        longint unsigned lo;
        longint unsigned hi;
        longint unsigned mid;
        lo = 0;
        hi = 64'd1 << 25;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    function automatic logic [31:0] model_root(input logic [31:0] rad);
        longint unsigned v;
        longint unsigned r;
        if (rad[31]) return 32'd0;
        v = {16'd0, rad, 16'd0};
        r = isqrt(v);
`ifdef SQRT_ROUND_EN
        if (v - r * r > r) r = r + 1;
`endif
        return r[31:0];
    endfunction

    // Count edges after the accept edge until ready is seen high (bounded)
    task automatic wait_ready(output int lat);
        lat = 0;
        while (!ready && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [31:0] rad, output logic [31:0] r, output logic e, output int lat);
        radicand = rad;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_ready(lat);
        r = root;
        e = err;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int          lat;
        logic [31:0] rad;

        checks   = 0;
        failures = 0;
        start    = 1'b0;
        radicand = '0;
        reset    = 1'b0;

        vecs[0] = '{32'h0004_0000, 32'h0002_0000, 1'b0, 25};
`ifdef SQRT_ROUND_EN
        vecs[1] = '{32'h0002_0000, 32'h0001_6A0A, 1'b0, 25};
`else
        vecs[1] = '{32'h0002_0000, 32'h0001_6A09, 1'b0, 25};
`endif
        vecs[2] = '{32'h7FFF_FFFF, 32'h00B5_04F3, 1'b0, 25};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 25};
        vecs[4] = '{32'hFFFF_0000, 32'h0000_0000, 1'b1, 1};
        vecs[5] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 25};
        vecs[6] = '{32'h8000_0000, 32'h0000_0000, 1'b1, 1};
        vecs[7] = '{32'h0009_0000, 32'h0003_0000, 1'b0, 25};

        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs", {28'd0, ready, busy, err, 1'b0, root}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].rad, r, e, lat);
            check($sformatf("vec%0d_root", i), 64'(r), 64'(vecs[i].exp_root));
            check($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
        end

        // Result holds while no new request arrives
        run_op(32'h0004_0000, r, e, lat);
        repeat (5) @(posedge clock);
        #1;
        check("hold_ready", 64'(ready), 64'd1);
        check("hold_busy", 64'(busy), 64'd0);
        check("hold_root", 64'(root), 64'h0002_0000);

        // Start during CALC is ignored
        radicand = 32'h0009_0000;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("calc_busy", 64'(busy), 64'd1);
        lat = 0;
        while (!ready && lat < 100) begin
            start    = (lat == 10);
            radicand = (lat == 10) ? 32'h0064_0000 : 32'h0009_0000;
            @(posedge clock);
            #1;
            lat++;
        end
        start = 1'b0;
        check("ignored_start_latency", 64'(lat), 64'd25);
        check("ignored_start_root", 64'(root), 64'h0003_0000);
        check("done_busy", 64'(busy), 64'd0);

        // Start in DONE begins the next operation, ready drops on that edge
        radicand = 32'h0019_0000;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("restart_ready_drop", 64'(ready), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
        wait_ready(lat);
        check("restart_latency", 64'(lat), 64'd25);
        check("restart_root", 64'(root), 64'h0005_0000);

        // Reset mid-CALC aborts immediately
        radicand = 32'h0009_0000;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("abort_outputs", {28'd0, ready, busy, err, 1'b0, root}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_no_result", 64'({ready, busy}), 64'd0);
        run_op(32'h0019_0000, r, e, lat);
        check("post_reset_root", 64'(r), 64'h0005_0000);
        check("post_reset_latency", 64'(lat), 64'd25);

        // Random operands against the reference
        for (int i = 0; i < 40; i++) begin
            rad = $urandom;
            if ($urandom_range(0, 3) != 0) rad[31] = 1'b0;
            if ($urandom_range(0, 3) == 0) rad = rad >> $urandom_range(0, 31);
            run_op(rad, r, e, lat);
            check($sformatf("rand%0d_root(rad=0x%0h)", i, rad), 64'(r), 64'(model_root(rad)));
            check($sformatf("rand%0d_err", i), 64'(e), 64'(rad[31]));
            check($sformatf("rand%0d_latency", i), 64'(lat), rad[31] ? 64'd1 : 64'd25);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
